// File: rtl/evm_pkg.sv
// Shared types and helpers for the ballot controller slice.
package evm_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StArmed  = 3'd1,
        StGrant  = 3'd2,
        StHold   = 3'd3,
        StClosed = 3'd4
    } ballot_state_e;

    // Default number of candidate request lines.
    localparam int unsigned NUM_CAND_DEF = 4;
    // Default statistics counter width.
    localparam int unsigned CNT_W_DEF    = 8;
    // Widest request vector the hot classifier accepts; NUM_CAND must not exceed this.
    localparam int unsigned MAX_CAND     = 16;

    // Classification of a request vector.
    typedef enum logic [1:0] {
        HotNone  = 2'd0,
        HotOne   = 2'd1,
        HotMulti = 2'd2
    } hot_e;

    // Clearing the lowest set bit leaves a non-zero value only if two or more bits were set.
    function automatic hot_e hot_class(input logic [MAX_CAND-1:0] vec);
        hot_e cls;
        if (vec == '0) begin
            cls = HotNone;
        end else if ((vec & (vec - MAX_CAND'(1))) != '0) begin
            cls = HotMulti;
        end else begin
            cls = HotOne;
        end
        return cls;
    endfunction

endpackage

// File: rtl/evm_sat_counter.sv
// Enable-driven saturating counter; holds at all-ones instead of wrapping.
module evm_sat_counter
    import evm_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Count enabled events, stopping at the maximum value.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + CntOne;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ballot_controller.sv
// Presiding-officer ballot sequencer: arms one ballot, accepts one unambiguous press,
// issues a one-cycle one-hot grant, then holds a confirm window.
// Optional macro BALLOT_SPOIL_COUNT_EN builds the spoiled-ballot counter; without it
// o_spoiled_count reads 0 but multi-press ballots are still voided.
module ballot_controller
    import evm_pkg::*;
#(
    parameter int unsigned NUM_CAND       = NUM_CAND_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned HOLD_CYCLES    = 10,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_mode,
    input  logic                i_arm,
    input  logic                i_close_poll,
    input  logic [NUM_CAND-1:0] i_vote_req,
    output logic [NUM_CAND-1:0] o_vote_grant,
    output logic                o_ballot_armed,
    output logic                o_confirm,
    output logic                o_poll_closed,
    output logic [CNT_W-1:0]    o_ballot_count,
    output logic [CNT_W-1:0]    o_timeout_count,
    output logic [CNT_W-1:0]    o_spoiled_count
);

    // One timer serves both the armed wait and the hold window.
    localparam int unsigned TmrMax =
        (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);

    localparam logic [TmrW-1:0] TmrOne     = TmrW'(1);
    localparam logic [TmrW-1:0] TimeoutEnd = TmrW'(TIMEOUT_CYCLES - 1);
    localparam logic [TmrW-1:0] HoldEnd    = TmrW'(HOLD_CYCLES - 1);

    ballot_state_e       r_state;
    ballot_state_e       w_state_next;
    logic [TmrW-1:0]     r_timer;
    logic [TmrW-1:0]     w_timer_next;
    logic [NUM_CAND-1:0] r_vote_grant;
    logic [NUM_CAND-1:0] w_grant_next;
    logic                r_armed;
    logic                r_confirm;
    logic                r_closed;
    logic                w_inc_ballot;
    logic                w_inc_timeout;
`ifdef BALLOT_SPOIL_COUNT_EN
    logic                w_inc_spoil;
`endif
    hot_e                w_req_class;

    assign w_req_class = hot_class(MAX_CAND'(i_vote_req));

    // Next-state and counter-event decode.
    always_comb begin
        w_state_next  = r_state;
        w_timer_next  = r_timer;
        w_grant_next  = '0;
        w_inc_ballot  = 1'b0;
        w_inc_timeout = 1'b0;
`ifdef BALLOT_SPOIL_COUNT_EN
        w_inc_spoil   = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (i_close_poll) begin
                    w_state_next = StClosed;
                end else if (i_arm && !i_mode) begin
                    w_state_next = StArmed;
                    w_timer_next = '0;
                end
            end
            StArmed: begin
                // Switching to results display voids the ballot silently.
                if (i_mode) begin
                    w_state_next = StIdle;
                end else if (w_req_class == HotMulti) begin
                    w_state_next = StIdle;
`ifdef BALLOT_SPOIL_COUNT_EN
                    w_inc_spoil  = 1'b1;
`endif
                end else if (w_req_class == HotOne) begin
                    // A press in the expiry cycle wins because it is checked first.
                    w_state_next = StGrant;
                    w_grant_next = i_vote_req;
                    w_inc_ballot = 1'b1;
                end else if (r_timer == TimeoutEnd) begin
                    w_state_next  = StIdle;
                    w_inc_timeout = 1'b1;
                end else begin
                    w_timer_next = r_timer + TmrOne;
                end
            end
            StGrant: begin
                w_state_next = StHold;
                w_timer_next = '0;
            end
            StHold: begin
                if (r_timer == HoldEnd) begin
                    w_state_next = StIdle;
                end else begin
                    w_timer_next = r_timer + TmrOne;
                end
            end
            StClosed: begin
                w_state_next = StClosed;
            end
            default: begin
                w_state_next = StIdle;
                w_timer_next = '0;
            end
        endcase
    end

    // State, timer and registered outputs, all derived from the next state.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= StIdle;
            r_timer      <= '0;
            r_vote_grant <= '0;
            r_armed      <= 1'b0;
            r_confirm    <= 1'b0;
            r_closed     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_timer      <= w_timer_next;
            r_vote_grant <= w_grant_next;
            r_armed      <= (w_state_next == StArmed);
            r_confirm    <= (w_state_next == StHold);
            r_closed     <= (w_state_next == StClosed);
        end
    end

    evm_sat_counter #(
        .CNT_W (CNT_W)
    ) u_ballot_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_en    (w_inc_ballot),
        .o_count (o_ballot_count)
    );

    evm_sat_counter #(
        .CNT_W (CNT_W)
    ) u_timeout_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_en    (w_inc_timeout),
        .o_count (o_timeout_count)
    );

`ifdef BALLOT_SPOIL_COUNT_EN
    evm_sat_counter #(
        .CNT_W (CNT_W)
    ) u_spoiled_cnt (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_en    (w_inc_spoil),
        .o_count (o_spoiled_count)
    );
`else
    assign o_spoiled_count = '0;
`endif

    assign o_vote_grant   = r_vote_grant;
    assign o_ballot_armed = r_armed;
    assign o_confirm      = r_confirm;
    assign o_poll_closed  = r_closed;

endmodule

// File: tb/tb_ballot_controller.sv
// Directed self-checking bench for ballot_controller (TIMEOUT_CYCLES=20, HOLD_CYCLES=10).
module tb_ballot_controller;

    logic       clock;
    logic       reset;
    logic       mode;
    logic       arm;
    logic       close_poll;
    logic [3:0] vote_req;
    logic [3:0] vote_grant;
    logic       ballot_armed;
    logic       confirm;
    logic       poll_closed;
    logic [7:0] ballot_count;
    logic [7:0] timeout_count;
    logic [7:0] spoiled_count;

    int checks   = 0;
    int failures = 0;

`ifdef BALLOT_SPOIL_COUNT_EN
    localparam logic [7:0] SpoilExp = 8'd1;
`else
    localparam logic [7:0] SpoilExp = 8'd0;
`endif

    ballot_controller #(
        .NUM_CAND       (4),
        .TIMEOUT_CYCLES (20),
        .HOLD_CYCLES    (10),
        .CNT_W          (8)
    ) dut (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_mode          (mode),
        .i_arm           (arm),
        .i_close_poll    (close_poll),
        .i_vote_req      (vote_req),
        .o_vote_grant    (vote_grant),
        .o_ballot_armed  (ballot_armed),
        .o_confirm       (confirm),
        .o_poll_closed   (poll_closed),
        .o_ballot_count  (ballot_count),
        .o_timeout_count (timeout_count),
        .o_spoiled_count (spoiled_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; mode = 1'b0; arm = 1'b0; close_poll = 1'b0; vote_req = 4'b0;
        #23;
        checks++;
        if ({vote_grant, ballot_armed, confirm, poll_closed} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {vote_grant, ballot_armed, confirm, poll_closed});
        end
        checks++;
        if ({ballot_count, timeout_count, spoiled_count} !== 24'h0) begin
            failures++;
            $display("FAIL reset_counts: got %h want 000000",
                     {ballot_count, timeout_count, spoiled_count});
        end
        @(negedge clock);
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_vote();
        int conf_cycles;
        int grant_seen;
        pulse_arm();
        checks++;
        if (ballot_armed !== 1'b1) begin
            failures++;
            $display("FAIL single_armed: got %b want 1", ballot_armed);
        end
        steps(2);
        vote_req = 4'b0010;
        step();
        vote_req = 4'b0;
        checks++;
        if (vote_grant !== 4'b0010) begin
            failures++;
            $display("FAIL single_grant: got %b want 0010", vote_grant);
        end
        conf_cycles = 0;
        grant_seen  = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (confirm === 1'b1) conf_cycles++;
            if (vote_grant !== 4'b0) grant_seen++;
        end
        checks++;
        if (conf_cycles != 10) begin
            failures++;
            $display("FAIL single_confirm_len: got %0d want 10", conf_cycles);
        end
        checks++;
        if (grant_seen != 0) begin
            failures++;
            $display("FAIL single_grant_width: extra grant cycles %0d want 0", grant_seen);
        end
        checks++;
        if ({ballot_count, ballot_armed} !== {8'd1, 1'b0}) begin
            failures++;
            $display("FAIL single_count: got count=%0d armed=%b want count=1 armed=0",
                     ballot_count, ballot_armed);
        end
    endtask

    // Casts a fresh ballot (count goes to 2), then retries during HOLD and in IDLE.
    task automatic test_double_vote();
        int grant_seen;
        pulse_arm();
        vote_req = 4'b0100;
        step();
        vote_req = 4'b0;
        checks++;
        if ({vote_grant, ballot_count} !== {4'b0100, 8'd2}) begin
            failures++;
            $display("FAIL double_first_grant: got %b/%0d want 0100/2", vote_grant, ballot_count);
        end
        steps(3);
        grant_seen = 0;
        vote_req = 4'b0001;
        step();
        vote_req = 4'b0;
        if (vote_grant !== 4'b0) grant_seen++;
        for (int i = 0; i < 12; i++) begin
            step();
            if (vote_grant !== 4'b0) grant_seen++;
        end
        vote_req = 4'b0001;
        step();
        vote_req = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (vote_grant !== 4'b0 || ballot_armed !== 1'b0) grant_seen++;
            step();
        end
        checks++;
        if (grant_seen != 0 || ballot_count !== 8'd2) begin
            failures++;
            $display("FAIL double_retry: got grants=%0d count=%0d want grants=0 count=2",
                     grant_seen, ballot_count);
        end
    endtask

    task automatic test_spoil();
        int bad;
        pulse_arm();
        vote_req = 4'b0101;
        step();
        vote_req = 4'b0;
        checks++;
        if ({vote_grant, ballot_armed, spoiled_count} !== {4'b0, 1'b0, SpoilExp}) begin
            failures++;
            $display("FAIL spoil_result: got grant=%b armed=%b spoiled=%0d want 0000/0/%0d",
                     vote_grant, ballot_armed, spoiled_count, SpoilExp);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (vote_grant !== 4'b0 || confirm !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || ballot_count !== 8'd2) begin
            failures++;
            $display("FAIL spoil_after: got bad=%0d count=%0d want 0/2", bad, ballot_count);
        end
    endtask

    task automatic test_timeout();
        pulse_arm();
        steps(19);
        checks++;
        if (ballot_armed !== 1'b1 || timeout_count !== 8'd0) begin
            failures++;
            $display("FAIL timeout_early: got armed=%b to=%0d want 1/0", ballot_armed, timeout_count);
        end
        step();
        checks++;
        if (ballot_armed !== 1'b0 || timeout_count !== 8'd1) begin
            failures++;
            $display("FAIL timeout_expire: got armed=%b to=%0d want 0/1", ballot_armed, timeout_count);
        end
        step();
        // Press lands on the expiry cycle.
        pulse_arm();
        steps(19);
        vote_req = 4'b1000;
        step();
        vote_req = 4'b0;
        checks++;
        if ({vote_grant, timeout_count, ballot_count} !== {4'b1000, 8'd1, 8'd3}) begin
            failures++;
            $display("FAIL timeout_race: got grant=%b to=%0d bc=%0d want 1000/1/3",
                     vote_grant, timeout_count, ballot_count);
        end
        steps(12);
    endtask

    task automatic test_mode();
        pulse_arm();
        mode = 1'b1;
        step();
        checks++;
        if ({ballot_armed, ballot_count, timeout_count, spoiled_count} !==
            {1'b0, 8'd3, 8'd1, SpoilExp}) begin
            failures++;
            $display("FAIL mode_void: got armed=%b bc=%0d to=%0d sp=%0d want 0/3/1/%0d",
                     ballot_armed, ballot_count, timeout_count, spoiled_count, SpoilExp);
        end
        pulse_arm();
        checks++;
        if (ballot_armed !== 1'b0) begin
            failures++;
            $display("FAIL mode_arm_ignored: got armed=%b want 0", ballot_armed);
        end
        mode = 1'b0;
        step();
    endtask

    task automatic test_close();
        pulse_arm();
        close_poll = 1'b1;
        steps(2);
        checks++;
        if (ballot_armed !== 1'b1 || poll_closed !== 1'b0) begin
            failures++;
            $display("FAIL close_deferred: got armed=%b closed=%b want 1/0", ballot_armed, poll_closed);
        end
        vote_req = 4'b0001;
        step();
        vote_req = 4'b0;
        checks++;
        if (vote_grant !== 4'b0001) begin
            failures++;
            $display("FAIL close_grant: got %b want 0001", vote_grant);
        end
        steps(10);
        checks++;
        if (confirm !== 1'b1 || poll_closed !== 1'b0) begin
            failures++;
            $display("FAIL close_hold: got confirm=%b closed=%b want 1/0", confirm, poll_closed);
        end
        step();
        checks++;
        if (confirm !== 1'b0 || poll_closed !== 1'b0) begin
            failures++;
            $display("FAIL close_idle: got confirm=%b closed=%b want 0/0", confirm, poll_closed);
        end
        step();
        checks++;
        if (poll_closed !== 1'b1) begin
            failures++;
            $display("FAIL close_closed: got %b want 1", poll_closed);
        end
        close_poll = 1'b0;
        pulse_arm();
        vote_req = 4'b0010;
        step();
        vote_req = 4'b0;
        checks++;
        if ({vote_grant, ballot_armed, poll_closed, ballot_count} !== {4'b0, 1'b0, 1'b1, 8'd4}) begin
            failures++;
            $display("FAIL close_terminal: got grant=%b armed=%b closed=%b bc=%0d want 0000/0/1/4",
                     vote_grant, ballot_armed, poll_closed, ballot_count);
        end
    endtask

    task automatic test_reset_hold();
        int grant_seen;
        reset = 1'b0;
        #12;
        @(negedge clock);
        reset = 1'b1;
        step();
        pulse_arm();
        vote_req = 4'b0100;
        step();
        vote_req = 4'b0;
        steps(3);
        checks++;
        if (confirm !== 1'b1 || ballot_count !== 8'd1) begin
            failures++;
            $display("FAIL rst_pre_hold: got confirm=%b bc=%0d want 1/1", confirm, ballot_count);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({vote_grant, ballot_armed, confirm, poll_closed, ballot_count} !== 15'b0) begin
            failures++;
            $display("FAIL rst_async: got %b want all zero",
                     {vote_grant, ballot_armed, confirm, poll_closed, ballot_count});
        end
        @(negedge clock);
        reset = 1'b1;
        grant_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (vote_grant !== 4'b0 || confirm !== 1'b0) grant_seen++;
        end
        checks++;
        if (grant_seen != 0) begin
            failures++;
            $display("FAIL rst_discard: got active cycles %0d want 0", grant_seen);
        end
    endtask

    // Starts from the post-reset state left by test_reset_hold.
    task automatic test_saturation();
        int         bad;
        logic [3:0] onehot;
        bad = 0;
        for (int i = 0; i < 260; i++) begin
            onehot = 4'b0001 << (i % 4);
            pulse_arm();
            vote_req = onehot;
            step();
            vote_req = 4'b0;
            if (vote_grant !== onehot) bad++;
            steps(11);
            if (i == 254) begin
                checks++;
                if (ballot_count !== 8'd255) begin
                    failures++;
                    $display("FAIL sat_reach: got %0d want 255", ballot_count);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sat_grants: got %0d wrong grants want 0", bad);
        end
        checks++;
        if ({ballot_count, timeout_count, spoiled_count} !== {8'd255, 8'd0, 8'd0}) begin
            failures++;
            $display("FAIL sat_hold: got bc=%0d to=%0d sp=%0d want 255/0/0",
                     ballot_count, timeout_count, spoiled_count);
        end
    endtask

    // Flags any multi-hot grant observed at any point in the run.
    always @(negedge clock) begin
        if (reset && ((vote_grant & (vote_grant - 4'd1)) != 4'b0)) begin
            failures++;
            $display("FAIL grant_multihot: got %b want at most one bit", vote_grant);
        end
    end

    initial begin
        test_reset();
        test_single_vote();
        test_double_vote();
        test_spoil();
        test_timeout();
        test_mode();
        test_close();
        test_reset_hold();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
